// File: rtl/fast_pkg.sv
// Shared pixel types and circle geometry for the FAST corner path.
package fast_pkg;
  typedef logic [7:0] pixel_t;
  typedef pixel_t [0:15] circle_t;

  localparam int CIRCLE_N        = 16;
  localparam int RADIUS          = 3;
  localparam int ARC_LEN_DEFAULT = 9;
endpackage

// File: rtl/fast_arc_detect.sv
// Combinational search for a run of ARC_LEN set flags on the 16-entry circle,
// wrapping from index 15 back to index 0.
module fast_arc_detect
  import fast_pkg::*;
#(
  parameter int ARC_LEN = ARC_LEN_DEFAULT
) (
  input  logic [CIRCLE_N-1:0] i_flags,
  output logic                o_any
);

  logic [CIRCLE_N-1:0] arc;

  // arc[s] is set when every flag from s to s+ARC_LEN-1 (mod 16) is set.
  always_comb begin
    logic [3:0] idx;
    arc = '1;
    idx = '0;
    for (int s = 0; s < CIRCLE_N; s++) begin
      for (int i = 0; i < ARC_LEN; i++) begin
        idx    = 4'(s + i);
        arc[s] = arc[s] & i_flags[idx];
      end
    end
  end

  assign o_any = |arc;

endmodule

// File: rtl/fast_segment_test.sv
// FAST segment test: two-stage pipeline turning circle pixels into a corner
// flag with raster coordinates, border masking and a per-frame corner count.
module fast_segment_test
  import fast_pkg::*;
#(
  parameter  int RESOLUTION_X = 320,
  parameter  int RESOLUTION_Y = 240,
  parameter  int ARC_LEN      = ARC_LEN_DEFAULT,
  localparam int XW           = $clog2(RESOLUTION_X),
  localparam int YW           = $clog2(RESOLUTION_Y)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [0:15][7:0] i_circle,
  input  logic [7:0]       i_ctr,
  input  logic             i_v,
  input  logic [7:0]       i_thresh,
  output logic             o_v,
  output logic             o_corner,
  output logic [XW-1:0]    o_x,
  output logic [YW-1:0]    o_y,
  output logic             o_frame_done,
  output logic [15:0]      o_corner_count
);

  localparam logic [XW-1:0] X_LAST = XW'(RESOLUTION_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(RESOLUTION_Y - 1);
  localparam logic [XW-1:0] X_LO   = XW'(RADIUS);
  localparam logic [XW-1:0] X_HI   = XW'(RESOLUTION_X - 1 - RADIUS);
  localparam logic [YW-1:0] Y_LO   = YW'(RADIUS);
  localparam logic [YW-1:0] Y_HI   = YW'(RESOLUTION_Y - 1 - RADIUS);

  logic [XW-1:0] x_q, x_d, x_p1_q, x_p1_d, x_p2_q, x_p2_d;
  logic [YW-1:0] y_q, y_d, y_p1_q, y_p1_d, y_p2_q, y_p2_d;
  logic          vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic          done_p1_q, done_p1_d, done_p2_q, done_p2_d;
  logic          border_p1_q, border_p1_d;
  logic [15:0]   bright_p1_q, bright_p1_d, dark_p1_q, dark_p1_d;
  logic          corner_p2_q, corner_p2_d;
  logic [15:0]   cnt_q, cnt_d, count_q, count_d, cnt_total;
  logic          any_b, any_d;

  // Raster position of the pixel currently on the input.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_v) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // ---- stage 1: threshold compares in 9 bits, border and frame-end tags ----
  always_comb begin
    logic [8:0] ctr9, hi9;
    ctr9 = {1'b0, i_ctr};
    hi9  = ctr9 + {1'b0, i_thresh};
    for (int k = 0; k < CIRCLE_N; k++) begin
      bright_p1_d[k] = {1'b0, i_circle[k]} > hi9;
      dark_p1_d[k]   = ({1'b0, i_circle[k]} + {1'b0, i_thresh}) < ctr9;
    end
    border_p1_d = (x_q < X_LO) || (x_q > X_HI) || (y_q < Y_LO) || (y_q > Y_HI);
    done_p1_d   = i_v && (x_q == X_LAST) && (y_q == Y_LAST);
    vld_p1_d    = i_v;
    x_p1_d      = x_q;
    y_p1_d      = y_q;
  end

  fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_bright (
    .i_flags (bright_p1_q),
    .o_any   (any_b)
  );

  fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_dark (
    .i_flags (dark_p1_q),
    .o_any   (any_d)
  );

  // ---- stage 2: arc decision, border mask and corner accounting ----
  always_comb begin
    vld_p2_d    = vld_p1_q;
    corner_p2_d = vld_p1_q && (any_b || any_d) && !border_p1_q;
    done_p2_d   = vld_p1_q && done_p1_q;
    x_p2_d      = vld_p1_q ? x_p1_q : x_p2_q;
    y_p2_d      = vld_p1_q ? y_p1_q : y_p2_q;
    cnt_total   = cnt_q;
    if (corner_p2_d && (cnt_q != 16'hFFFF)) cnt_total = cnt_q + 16'd1;
    // The frame-end pixel is folded into the published total before the clear.
    cnt_d   = done_p2_d ? 16'd0 : cnt_total;
    count_d = done_p2_d ? cnt_total : count_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      vld_p1_q    <= 1'b0;
      done_p1_q   <= 1'b0;
      vld_p2_q    <= 1'b0;
      corner_p2_q <= 1'b0;
      done_p2_q   <= 1'b0;
      x_p2_q      <= '0;
      y_p2_q      <= '0;
      cnt_q       <= '0;
      count_q     <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vld_p1_q    <= vld_p1_d;
      done_p1_q   <= done_p1_d;
      vld_p2_q    <= vld_p2_d;
      corner_p2_q <= corner_p2_d;
      done_p2_q   <= done_p2_d;
      x_p2_q      <= x_p2_d;
      y_p2_q      <= y_p2_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
    end
  end

  // Datapath registers are only observed when qualified by a valid.
  always_ff @(posedge i_clk) begin
    bright_p1_q <= bright_p1_d;
    dark_p1_q   <= dark_p1_d;
    border_p1_q <= border_p1_d;
    x_p1_q      <= x_p1_d;
    y_p1_q      <= y_p1_d;
  end

  assign o_v            = vld_p2_q;
  assign o_corner       = corner_p2_q;
  assign o_x            = x_p2_q;
  assign o_y            = y_p2_q;
  assign o_frame_done   = done_p2_q;
  assign o_corner_count = count_q;

endmodule
